// File: rtl/cdc_pulse_arb.sv
// cdc_pulse_arb: round-robin scheduler that shares one toggle-based
// clock-domain-crossing channel between N local requesters.
//
// Each accepted request flips o_tgl once and then waits for the far side's
// acknowledge. That acknowledge arrives here as the single-cycle pulse i_ack_p.
// Only one transfer is outstanding at a time.
//
// Optional feature macro: CDC_PULSE_ARB_TIMEOUT_EN
//   - Defined: a TIMEOUT_W-bit counter aborts a WAIT that has gone on too long.
//     The abort raises o_err for one cycle.
//   - Undefined: no counter is built, o_err is tied low and WAIT lasts until
//     i_ack_p.
//
// Handshake contract, kept in this one place:
//   - i_req[k] is a one-cycle pulse. It is latched into a pending bit, and
//     repeat pulses merge into that bit.
//   - A grant is issued from the registered pending vector, so it is always
//     visible one edge after the request is sampled.
//   - o_grant, o_id and o_busy hold for the whole transfer.
//   - The transfer ends on the edge that samples i_ack_p (o_done[k] pulses) or,
//     with the timeout built, on the timeout edge (o_err pulses).
//   - An ack that arrives while idle is ignored.
module cdc_pulse_arb #(
    parameter int N         = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_id,
    output logic                 o_tgl,
    input  logic                 i_ack_p,
    output logic [N-1:0]         o_done,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_state
);

    localparam int IW = $clog2(N);

    // Reject parameter values outside the supported range at elaboration.
    if (N < 2 || N > 16 || TIMEOUT_W < 1) begin : g_param_check
        $error("cdc_pulse_arb: N must be 2..16 and TIMEOUT_W at least 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t         state_q, state_n;
    logic [N-1:0]   pend_q, pend_n;
    logic [IW-1:0]  last_q, last_n;
    logic [N-1:0]   grant_q, grant_n;
    logic [IW-1:0]  id_q, id_n;
    logic           tgl_q, tgl_n;
    logic [N-1:0]   done_q, done_n;
    logic           busy_q, busy_n;
    logic [N-1:0]   clr;

    logic           win_found;
    logic [IW-1:0]  win_idx;
    logic [IW-1:0]  cand_idx;
    int             cand;

`ifdef CDC_PULSE_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_n;
    logic                 err_q, err_n;
`endif

    // Round-robin winner: scan pending bits starting just after the last grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(last_q) + i) % N;
            cand_idx = IW'(cand);
            if (!win_found && pend_q[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT transfer FSM.
    always_comb begin
        state_n = state_q;
        last_n  = last_q;
        grant_n = grant_q;
        id_n    = id_q;
        tgl_n   = tgl_q;
        done_n  = '0;
        busy_n  = busy_q;
        clr     = '0;
`ifdef CDC_PULSE_ARB_TIMEOUT_EN
        cnt_n   = cnt_q;
        err_n   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A spurious i_ack_p here is deliberately not looked at.
                if (win_found) begin
                    state_n = S_WAIT;
                    last_n  = win_idx;
                    id_n    = win_idx;
                    grant_n = N'(1) << win_idx;
                    clr     = N'(1) << win_idx;
                    tgl_n   = ~tgl_q;
                    busy_n  = 1'b1;
`ifdef CDC_PULSE_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            S_WAIT: begin
`ifdef CDC_PULSE_ARB_TIMEOUT_EN
                cnt_n = cnt_q + 1'b1;
`endif
                if (i_ack_p) begin
                    // The ack wins even when it lands on the timeout edge.
                    state_n = S_IDLE;
                    done_n  = grant_q;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end
`ifdef CDC_PULSE_ARB_TIMEOUT_EN
                else if (cnt_q == '1) begin
                    // Abandon the transfer. o_tgl stays where it is, so a late
                    // ack from the far side just lands in IDLE.
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end
`endif
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // A request arriving on the granting edge re-arms its pending bit.
        pend_n = (pend_q & ~clr) | i_req;
    end

    // State, pending vector, round-robin pointer and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            last_q  <= IW'(N - 1);
            grant_q <= '0;
            id_q    <= '0;
            tgl_q   <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pend_q  <= pend_n;
            last_q  <= last_n;
            grant_q <= grant_n;
            id_q    <= id_n;
            tgl_q   <= tgl_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
        end
    end

`ifdef CDC_PULSE_ARB_TIMEOUT_EN
    // Acknowledge-timeout counter and the one-cycle error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            err_q <= err_n;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_grant = grant_q;
    assign o_id    = id_q;
    assign o_tgl   = tgl_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_state = (state_q == S_WAIT);

endmodule

// File: tb/tb_cdc_pulse_arb.sv
// Directed testbench for cdc_pulse_arb (N=4, TIMEOUT_W=3).
// The timeout scenario follows CDC_PULSE_ARB_TIMEOUT_EN, the same macro the
// design uses.
module tb_cdc_pulse_arb;

  localparam int N  = 4;
  localparam int TW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         ack;
  logic [N-1:0] grant;
  logic [1:0]   id;
  logic         tgl;
  logic [N-1:0] done;
  logic         err;
  logic         busy;
  logic         st;

  int   total = 0;
  int   bad   = 0;
  logic exp_tgl;
  int   tgl_cnt = 0;
  logic tgl_prev = 1'b0;

  // clock and reset
  always #5 clk = ~clk;

  cdc_pulse_arb #(.N(N), .TIMEOUT_W(TW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .o_grant (grant),
    .o_id    (id),
    .o_tgl   (tgl),
    .i_ack_p (ack),
    .o_done  (done),
    .o_err   (err),
    .o_busy  (busy),
    .o_state (st)
  );

  // toggle edge monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (tgl !== tgl_prev) tgl_cnt++;
    tgl_prev = tgl;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [N-1:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_tgl = 1'b0;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    total++; if (id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", id); end
    total++; if (tgl !== 1'b0 || done !== 4'b0000 || err !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL reset_outs got tgl=%b done=%b err=%b busy=%b want 0", tgl, done, err, busy); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] eg;
    tgl_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      pulse_req(4'b1111);
      for (int k = 0; k < N; k++) begin
        eg = 4'b0001 << k;
        tick();
        exp_tgl = ~exp_tgl;
        total++; if (grant !== eg || id !== 2'(k))
          begin bad++; $display("FAIL fair_grant r=%0d got=%b/%0d want=%b/%0d", r, grant, id, eg, k); end
        total++; if (tgl !== exp_tgl || busy !== 1'b1)
          begin bad++; $display("FAIL fair_tgl got tgl=%b busy=%b want tgl=%b busy=1", tgl, busy, exp_tgl); end
        tick(); tick();
        ack_pulse();
        total++; if (done !== eg) begin bad++; $display("FAIL fair_done got=%b want=%b", done, eg); end
      end
      tick();
      total++; if (busy !== 1'b0 || grant !== 4'b0000)
        begin bad++; $display("FAIL fair_idle got busy=%b grant=%b want 0", busy, grant); end
    end
    total++; if (tgl_cnt !== 8) begin bad++; $display("FAIL fair_tgl_count got=%0d want=8", tgl_cnt); end
  endtask

  task automatic test_single();
    pulse_req(4'b0100);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_early got busy=%b want=0", busy); end
    tick();
    exp_tgl = ~exp_tgl;
    total++; if (grant !== 4'b0100 || id !== 2'd2)
      begin bad++; $display("FAIL single_grant got=%b/%0d want=0100/2", grant, id); end
    total++; if (tgl !== exp_tgl || busy !== 1'b1)
      begin bad++; $display("FAIL single_tgl got tgl=%b busy=%b want tgl=%b busy=1", tgl, busy, exp_tgl); end
    tick(); tick(); tick();
    total++; if (done !== 4'b0000 || busy !== 1'b1)
      begin bad++; $display("FAIL single_hold got done=%b busy=%b want 0000/1", done, busy); end
    ack_pulse();
    total++; if (done !== 4'b0100 || busy !== 1'b0 || grant !== 4'b0000)
      begin bad++; $display("FAIL single_done got done=%b busy=%b grant=%b want 0100/0/0000", done, busy, grant); end
    tick();
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_pulse got=%b want=0000", done); end
  endtask

  task automatic test_merge();
    pulse_req(4'b0001);
    tick();
    exp_tgl = ~exp_tgl;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL merge_g0 got=%b want=0001", grant); end
    pulse_req(4'b0010);
    tick();
    pulse_req(4'b0010);
    ack_pulse();
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL merge_d0 got=%b want=0001", done); end
    tick();
    exp_tgl = ~exp_tgl;
    total++; if (grant !== 4'b0010 || tgl !== exp_tgl)
      begin bad++; $display("FAIL merge_g1 got=%b tgl=%b want=0010 tgl=%b", grant, tgl, exp_tgl); end
    tick();
    ack_pulse();
    total++; if (done !== 4'b0010) begin bad++; $display("FAIL merge_d1 got=%b want=0010", done); end
    tick(); tick();
    total++; if (busy !== 1'b0 || grant !== 4'b0000 || tgl !== exp_tgl)
      begin bad++; $display("FAIL merge_once got busy=%b grant=%b tgl=%b want 0/0000/%b", busy, grant, tgl, exp_tgl); end
  endtask

  task automatic test_set_wins();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    exp_tgl = ~exp_tgl;
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL setwin_g1 got=%b want=0010", grant); end
    tick();
    ack_pulse();
    total++; if (done !== 4'b0010) begin bad++; $display("FAIL setwin_d1 got=%b want=0010", done); end
    tick();
    exp_tgl = ~exp_tgl;
    total++; if (grant !== 4'b0010 || tgl !== exp_tgl)
      begin bad++; $display("FAIL setwin_regrant got=%b tgl=%b want=0010 tgl=%b", grant, tgl, exp_tgl); end
    ack_pulse();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL setwin_idle got busy=%b want=0", busy); end
  endtask

  task automatic test_spurious_ack();
    ack_pulse();
    total++; if (done !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000 || st !== 1'b0)
      begin bad++; $display("FAIL spur_outs got done=%b busy=%b grant=%b st=%b want 0", done, busy, grant, st); end
    total++; if (tgl !== exp_tgl) begin bad++; $display("FAIL spur_tgl got=%b want=%b", tgl, exp_tgl); end
    tick();
    total++; if (busy !== 1'b0 || done !== 4'b0000)
      begin bad++; $display("FAIL spur_after got busy=%b done=%b want 0", busy, done); end
  endtask

`ifdef CDC_PULSE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    pulse_req(4'b0100);
    tick();
    exp_tgl = ~exp_tgl;
    repeat (7) tick();
    total++; if (err !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL to_early got err=%b busy=%b want 0/1", err, busy); end
    tick();
    total++; if (err !== 1'b1 || done !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000)
      begin bad++; $display("FAIL to_fire got err=%b done=%b busy=%b grant=%b want 1/0000/0/0000", err, done, busy, grant); end
    total++; if (tgl !== exp_tgl) begin bad++; $display("FAIL to_tgl got=%b want=%b", tgl, exp_tgl); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b want=0", err); end
    ack_pulse();
    total++; if (done !== 4'b0000 || busy !== 1'b0 || tgl !== exp_tgl)
      begin bad++; $display("FAIL to_late_ack got done=%b busy=%b tgl=%b want 0000/0/%b", done, busy, tgl, exp_tgl); end
    pulse_req(4'b0100);
    tick();
    exp_tgl = ~exp_tgl;
    repeat (7) tick();
    ack_pulse();
    total++; if (done !== 4'b0100 || err !== 1'b0)
      begin bad++; $display("FAIL to_ack_wins got done=%b err=%b want 0100/0", done, err); end
    tick();
  endtask
`else
  task automatic test_timeout();
    pulse_req(4'b0100);
    tick();
    exp_tgl = ~exp_tgl;
    repeat (20) tick();
    total++; if (busy !== 1'b1 || err !== 1'b0 || grant !== 4'b0100)
      begin bad++; $display("FAIL nto_wait got busy=%b err=%b grant=%b want 1/0/0100", busy, err, grant); end
    ack_pulse();
    total++; if (done !== 4'b0100 || err !== 1'b0)
      begin bad++; $display("FAIL nto_done got done=%b err=%b want 0100/0", done, err); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    pulse_req(4'b0001);
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rst_pre got=%b want=0001", grant); end
    pulse_req(4'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_tgl = 1'b0;
    total++; if (grant !== 4'b0000 || id !== 2'd0 || tgl !== 1'b0 || busy !== 1'b0 || done !== 4'b0000 || err !== 1'b0)
      begin bad++; $display("FAIL rst_outs got grant=%b id=%0d tgl=%b busy=%b done=%b err=%b want 0", grant, id, tgl, busy, done, err); end
    tick(); tick();
    total++; if (busy !== 1'b0 || done !== 4'b0000)
      begin bad++; $display("FAIL rst_pend got busy=%b done=%b want 0/0000", busy, done); end
    pulse_req(4'b1001);
    tick();
    exp_tgl = ~exp_tgl;
    total++; if (grant !== 4'b0001 || id !== 2'd0 || tgl !== exp_tgl)
      begin bad++; $display("FAIL rst_first got=%b/%0d tgl=%b want=0001/0 tgl=%b", grant, id, tgl, exp_tgl); end
    ack_pulse();
    tick();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL rst_second got=%b want=1000", grant); end
    ack_pulse();
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_merge();
    test_set_wins();
    test_spurious_ack();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
